// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ---- uart_pkg : shared state encoding and default sizes for the UART TX sequencer | rev 1.0 ----
package uart_pkg;

  localparam int DEFAULT_DATA_BITS = 8;
  localparam int DEFAULT_DIV_BITS  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
`timescale 1ns/1ps
// ---- uart_bit_timer : bit-period divider counting 1..period, flags the last cycle | rev 1.0 ----
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int DIV_BITS = DEFAULT_DIV_BITS
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                enable,
  input  logic [DIV_BITS-1:0] period,
  output logic                bit_tick
);

  logic [DIV_BITS-1:0] div_cnt;

  // Counting 1..period (never past period) keeps the full DIV_BITS range usable without wrap.
  assign bit_tick = enable && (div_cnt == period);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= DIV_BITS'(1);
    end else if (enable) begin
      div_cnt <= bit_tick ? DIV_BITS'(1) : div_cnt + DIV_BITS'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ---- uart_tx_frame_sequencer : serializes start, data (LSB first), parity and stop bits | rev 1.0 ----
module uart_tx_frame_sequencer
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int DIV_BITS  = DEFAULT_DIV_BITS
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic [DIV_BITS-1:0]  clks_per_bit,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop_two,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);

  uart_state_t          state, state_nxt;
  logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_nxt;
  logic [DIV_BITS-1:0]  period;
  logic                 par_en, par_bit, stop2;
  logic                 tx_nxt, busy_nxt, done_nxt;
  logic                 accept, timer_en, bit_tick;
  logic [IDX_W-1:0]     last_stop;

  assign timer_en  = (state != IDLE);
  assign last_stop = {{(IDX_W-1){1'b0}}, stop2};

  uart_bit_timer #(
    .DIV_BITS (DIV_BITS)
  ) u_bit_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (accept),
    .enable   (timer_en),
    .period   (period),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift_reg;
    tx_nxt      = tx_out;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    accept      = 1'b0;

    case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        if (start) begin
          accept      = 1'b1;
          state_nxt   = START;
          bit_idx_nxt = '0;
          shift_nxt   = data_in;
          tx_nxt      = 1'b0;
          busy_nxt    = 1'b1;
        end
      end
      START: begin
        if (bit_tick) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
          tx_nxt      = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_nxt = shift_reg >> 1;
          if (bit_idx == LAST_DATA) begin
            bit_idx_nxt = '0;
            state_nxt   = par_en ? PARITY : STOP;
            tx_nxt      = par_en ? par_bit : 1'b1;
          end else begin
            // Next data bit is presented one edge ahead of the shift landing.
            bit_idx_nxt = bit_idx + IDX_W'(1);
            tx_nxt      = shift_reg[1];
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_nxt   = STOP;
          bit_idx_nxt = '0;
          tx_nxt      = 1'b1;
        end
      end
      STOP: begin
        tx_nxt = 1'b1;
        if (bit_tick) begin
          if (bit_idx == last_stop) begin
            state_nxt   = IDLE;
            bit_idx_nxt = '0;
            busy_nxt    = 1'b0;
            done_nxt    = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        bit_idx_nxt = '0;
        tx_nxt      = 1'b1;
        busy_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_idx   <= '0;
      shift_reg <= '0;
      period    <= '0;
      par_en    <= 1'b0;
      par_bit   <= 1'b0;
      stop2     <= 1'b0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      bit_idx   <= bit_idx_nxt;
      shift_reg <= shift_nxt;
      tx_out    <= tx_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      if (accept) begin
        // A zero divider would never tick; run it as one cycle per bit instead.
        period  <= (clks_per_bit == '0) ? DIV_BITS'(1) : clks_per_bit;
        par_en  <= parity_en;
        par_bit <= (^data_in) ^ parity_odd;
        stop2   <= stop_two;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ---- tb_uart_tx_frame_sequencer : scoreboard bench, directed frames with hand-computed line bits | rev 1.0 ----
module tb_uart_tx_frame_sequencer;

  logic        clk, n_rst, start, parity_en, parity_odd, stop_two;
  logic [7:0]  data_in;
  logic [15:0] clks_per_bit;
  logic        tx_out, busy, done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // fbits[i] is the i-th bit placed on the line (bit 0 = start bit).
  typedef struct {
    logic [15:0] fbits;
    int          nbits;
    int          p;
    int          done_cyc;
    string       name;
  } exp_t;

  exp_t         exp_q[$];
  logic [255:0] cap;
  int           cap_len;

  uart_tx_frame_sequencer #(
    .DATA_BITS (8),
    .DIV_BITS  (16)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .data_in      (data_in),
    .clks_per_bit (clks_per_bit),
    .parity_en    (parity_en),
    .parity_odd   (parity_odd),
    .stop_two     (stop_two),
    .tx_out       (tx_out),
    .busy         (busy),
    .done         (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d simulation did not finish in time", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Called #1 after a posedge with the DUT idle; scrambles all inputs once the frame is accepted.
  task automatic issue(input logic [7:0] d, input logic [15:0] cpb, input logic pen,
                       input logic podd, input logic s2, input logic [15:0] fb,
                       input int nb, input int p, input bit push, input string name);
    data_in      = d;
    clks_per_bit = cpb;
    parity_en    = pen;
    parity_odd   = podd;
    stop_two     = s2;
    start        = 1'b1;
    if (push) begin
      exp_t e;
      e.fbits    = fb;
      e.nbits    = nb;
      e.p        = p;
      e.done_cyc = cyc + 1 + nb * p;
      e.name     = name;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, "_accept"}, 32'({busy, tx_out}), 32'b10);
    data_in      = ~d;
    clks_per_bit = cpb + 16'd5;
    parity_en    = ~pen;
    parity_odd   = ~podd;
    stop_two     = ~s2;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_done_timeout cyc=%0d actual=no_done required=done_within_300", name, cyc);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: captures the line while busy and scores the frame on each done pulse.
  initial begin
    exp_t e;
    int   mism;
    cap     = '0;
    cap_len = 0;
    forever begin
      @(negedge clk);
      if (n_rst !== 1'b1) begin
        cap_len = 0;
      end else begin
        if (busy === 1'b1) begin
          if (cap_len < 256) cap[cap_len] = tx_out;
          cap_len++;
        end else begin
          checks++;
          if (tx_out !== 1'b1) begin
            failures++;
            $display("FAIL idle_line cyc=%0d actual=%b required=1", cyc, tx_out);
          end
        end
        if (done === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done cyc=%0d actual=done required=no_done", cyc);
          end else begin
            e = exp_q.pop_front();
            checks++;
            if (cap_len != e.nbits * e.p) begin
              failures++;
              $display("FAIL %s_length actual=%0d required=%0d", e.name, cap_len, e.nbits * e.p);
            end
            mism = -1;
            for (int j = 0; j < e.nbits * e.p && j < 256; j++)
              if (mism < 0 && cap[j] !== e.fbits[j / e.p]) mism = j;
            checks++;
            if (mism >= 0) begin
              failures++;
              $display("FAIL %s_wave sample=%0d actual=%b required=%b", e.name, mism,
                       cap[mism], e.fbits[mism / e.p]);
            end
            checks++;
            if (cyc != e.done_cyc) begin
              failures++;
              $display("FAIL %s_done_cycle actual=%0d required=%0d", e.name, cyc, e.done_cyc);
            end
          end
          cap_len = 0;
        end
      end
    end
  end

  initial begin
    n_rst        = 1'b0;
    start        = 1'b0;
    data_in      = 8'h00;
    clks_per_bit = 16'd0;
    parity_en    = 1'b0;
    parity_odd   = 1'b0;
    stop_two     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("in_reset", 32'({tx_out, busy, done}), 32'b100);
    n_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("reset_idle", 32'({tx_out, busy, done}), 32'b100);
    end

    // 0xA5, 4 clocks/bit, no parity, one stop bit.
    issue(8'hA5, 16'd4, 1'b0, 1'b0, 1'b0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 4, 1'b1, "a5_p4");
    wait_done("a5_p4");
    idle_cycles(3);

    // 0x03 has even weight: even parity bit 0, odd parity bit 1.
    issue(8'h03, 16'd1, 1'b1, 1'b0, 1'b0, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11, 1, 1'b1, "par_even");
    wait_done("par_even");
    idle_cycles(2);
    issue(8'h03, 16'd1, 1'b1, 1'b1, 1'b0, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, 1, 1'b1, "par_odd");
    wait_done("par_odd");
    idle_cycles(2);

    // Two stop bits at 2 clocks/bit, with start pulses at cycles 5 and 10 that must be ignored.
    issue(8'h5A, 16'd2, 1'b0, 1'b0, 1'b1, {5'b0, 2'b11, 8'h5A, 1'b0}, 11, 2, 1'b1, "stop2");
    idle_cycles(4);
    start = 1'b1;
    idle_cycles(1);
    start = 1'b0;
    idle_cycles(4);
    start = 1'b1;
    idle_cycles(1);
    start = 1'b0;
    wait_done("stop2");

    // Back-to-back start in the done cycle; divider 0 runs as 1 clock/bit. 0xC3 even weight, odd parity -> 1.
    issue(8'hC3, 16'd0, 1'b1, 1'b1, 1'b0, {5'b0, 1'b1, 1'b1, 8'hC3, 1'b0}, 11, 1, 1'b1, "b2b_div0");
    wait_done("b2b_div0");
    idle_cycles(3);

    // Abort at cycle 15 of a 0x00 frame: line is low on data, must snap high with no done.
    issue(8'h00, 16'd4, 1'b0, 1'b0, 1'b0, 16'h0000, 10, 4, 1'b0, "abort");
    repeat (14) @(posedge clk);
    #4;
    check("pre_abort", 32'({tx_out, busy}), 32'b01);
    n_rst = 1'b0;
    #1;
    check("abort_async", 32'({tx_out, busy, done}), 32'b100);
    idle_cycles(3);
    n_rst = 1'b1;
    idle_cycles(3);
    check("post_abort_idle", 32'({tx_out, busy, done}), 32'b100);

    // Fresh frame after abort: 0x96 even weight, even parity -> 0.
    issue(8'h96, 16'd3, 1'b1, 1'b0, 1'b0, {5'b0, 1'b1, 1'b0, 8'h96, 1'b0}, 11, 3, 1'b1, "after_rst");
    wait_done("after_rst");
    idle_cycles(5);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
